// File: rtl/ex_muldiv_if.sv
// Request/result bundle between the EX-stage pipeline and the mul/div unit.
interface ex_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] Rdata1;
  logic [WIDTH-1:0] Rdata2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, Rdata1, Rdata2,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, Rdata1, Rdata2,
    output busy, done, hi, lo, div_zero
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit with HI/LO registers: shift-add multiply (or a
// single-cycle product when FAST_MUL=1) and restoring divide on operand magnitudes.
module ex_muldiv #(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  ex_muldiv_if.slave bus
);
  localparam int         CNT_W   = $clog2(WIDTH + 1);
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_nx;

  logic                    accept, wr_mthi, wr_mtlo;
  logic                    req_div, req_signed, req_fast;
  logic                    sign_a, sign_b;
  logic [WIDTH-1:0]        mag_a, mag_b;
  logic [CNT_W-1:0]        cnt;
  logic [2*WIDTH-1:0]      acc;
  logic [WIDTH-1:0]        opa, opb, raw_a;
  logic                    is_div, neg_res, neg_rem, dz;
  logic signed [2*WIDTH-1:0] prod_fix;
  logic signed [WIDTH-1:0] quo_fix, rem_fix;
  logic [WIDTH-1:0]        hi_q, lo_q;
  logic                    done_q, dz_q;

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] fast_product(input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b);
    return {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  endfunction

  // acc = {partial product, remaining multiplier bits}; the carry lands in the top bit.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] sum;
    sum = {1'b0, a[2*WIDTH-1:WIDTH]} + (a[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    return {sum, a[WIDTH-1:1]};
  endfunction

  // acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0]   d);
    logic [WIDTH:0] part, diff;
    part = a[2*WIDTH-1:WIDTH-1];
    diff = part - {1'b0, d};
    if (diff[WIDTH])
      return {part[WIDTH-1:0], a[WIDTH-2:0], 1'b0};
    else
      return {diff[WIDTH-1:0], a[WIDTH-2:0], 1'b1};
  endfunction

  assign req_div    = bus.op[1];
  assign req_signed = ~bus.op[0];
  assign req_fast   = FAST_MUL && !bus.op[1];
  assign sign_a     = req_signed & bus.Rdata1[WIDTH-1];
  assign sign_b     = req_signed & bus.Rdata2[WIDTH-1];
  assign mag_a      = cond_neg_w(bus.Rdata1, sign_a);
  assign mag_b      = cond_neg_w(bus.Rdata2, sign_b);

  assign prod_fix = $signed(cond_neg_2w(acc, neg_res));
  assign quo_fix  = $signed(cond_neg_w(acc[WIDTH-1:0], neg_res));
  assign rem_fix  = $signed(cond_neg_w(acc[2*WIDTH-1:WIDTH], neg_rem));

  // FIX also accepts a new mul/div so back-to-back ops run every WIDTH+1 cycles;
  // MTHI/MTLO only land while idle so they never collide with the FIX write.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    wr_mthi  = 1'b0;
    wr_mtlo  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (!bus.op[2]) begin
            accept   = 1'b1;
            state_nx = req_fast ? FIX : RUN;
          end else if (bus.op == OP_MTHI) begin
            wr_mthi = 1'b1;
          end else if (bus.op == OP_MTLO) begin
            wr_mtlo = 1'b1;
          end
        end
      end
      RUN: begin
        if (cnt == CNT_W'(WIDTH - 1)) state_nx = FIX;
      end
      FIX: begin
        state_nx = IDLE;
        if (bus.start && !bus.op[2]) begin
          accept   = 1'b1;
          state_nx = req_fast ? FIX : RUN;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nx;
  end

  // ---- operand latch / iteration stage ----
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt     <= '0;
      acc     <= '0;
      opa     <= '0;
      opb     <= '0;
      raw_a   <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz      <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      opa     <= mag_a;
      opb     <= mag_b;
      raw_a   <= bus.Rdata1;
      is_div  <= req_div;
      neg_res <= sign_a ^ sign_b;
      neg_rem <= sign_a;
      dz      <= req_div && (bus.Rdata2 == '0);
      if (req_fast)     acc <= fast_product(mag_a, mag_b);
      else if (req_div) acc <= {{WIDTH{1'b0}}, mag_a};
      else              acc <= {{WIDTH{1'b0}}, mag_b};
    end else if (state == RUN) begin
      cnt <= cnt + CNT_W'(1);
      acc <= is_div ? div_step(acc, opb) : mul_step(acc, opa);
    end
  end

  // ---- sign fix-up / HI-LO write stage ----
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= (state == FIX);
      dz_q   <= (state == FIX) && is_div && dz;
      if (state == FIX) begin
        if (!is_div) begin
          {hi_q, lo_q} <= prod_fix;
        end else if (dz) begin
          hi_q <= raw_a;
          lo_q <= '1;
        end else begin
          hi_q <= rem_fix;
          lo_q <= quo_fix;
        end
      end else if (wr_mthi) begin
        hi_q <= bus.Rdata1;
      end else if (wr_mtlo) begin
        lo_q <= bus.Rdata1;
      end
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: iterative and fast-multiply instances checked against an
// arithmetic reference model with directed corner cases and random operations.
module tb_ex_muldiv;
  localparam int W = 32;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic [W-1:0] cur_hi = '0;
  logic [W-1:0] cur_lo = '0;

  ex_muldiv_if #(.WIDTH(W)) s_if();
  ex_muldiv_if #(.WIDTH(W)) f_if();

  ex_muldiv #(.WIDTH(W), .FAST_MUL(1'b0)) dut_s (.CLK(CLK), .RST(RST), .bus(s_if));
  ex_muldiv #(.WIDTH(W), .FAST_MUL(1'b1)) dut_f (.CLK(CLK), .RST(RST), .bus(f_if));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference results straight from the arithmetic definition of each op.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, b,
                                input logic [W-1:0] ohi, olo,
                                output logic [W-1:0] h, l, output logic dz);
    longint      p, q, r;
    logic [63:0] pu;
    h = ohi; l = olo; dz = 1'b0;
    case (op)
      3'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        h = p[63:32]; l = p[31:0];
      end
      3'd1: begin
        pu = {32'd0, a} * {32'd0, b};
        h = pu[63:32]; l = pu[31:0];
      end
      3'd2, 3'd3: begin
        if (b == 0) begin
          l = '1; h = a; dz = 1'b1;
        end else if (op == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000; h = '0;
        end else if (op == 3'd2) begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          l = q[31:0]; h = r[31:0];
        end else begin
          l = a / b; h = a % b;
        end
      end
      3'd4: h = a;
      3'd5: l = a;
      default: ;
    endcase
  endfunction

  task automatic drive(input logic st, input logic [2:0] op, input logic [W-1:0] a, b);
    s_if.start = st; s_if.op = op; s_if.Rdata1 = a; s_if.Rdata2 = b;
    f_if.start = st; f_if.op = op; f_if.Rdata1 = a; f_if.Rdata2 = b;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, b,
                        input int glitch, input string tag);
    logic [W-1:0] eh, el;
    logic         ed;
    logic         fast_mul;
    int           busy_n, hold_bad;
    model(op, a, b, cur_hi, cur_lo, eh, el, ed);
    fast_mul = (op <= 3'd1);
    busy_n = 0; hold_bad = 0;
    @(negedge CLK); drive(1'b1, op, a, b);
    @(posedge CLK); #1;
    if (op[2]) begin
      chk({tag, "_hi"}, s_if.hi, eh);
      chk({tag, "_lo"}, s_if.lo, el);
      chk({tag, "_busy"}, s_if.busy, 1'b0);
      chk({tag, "_done"}, s_if.done, 1'b0);
      chk({tag, "_fhi"}, f_if.hi, eh);
      chk({tag, "_flo"}, f_if.lo, el);
      @(negedge CLK); drive(1'b0, 3'd7, '0, '0);
      cur_hi = eh; cur_lo = el;
      return;
    end
    chk({tag, "_busy_c0"}, s_if.busy, 1'b1);
    chk({tag, "_fbusy_c0"}, f_if.busy, 1'b1);
    @(negedge CLK); drive(1'b0, 3'd7, '0, '0);
    for (int n = 1; n <= W + 1; n++) begin
      @(posedge CLK); #1;
      if (n <= W) begin
        if (s_if.busy === 1'b1 && s_if.done === 1'b0) busy_n++;
        if (s_if.hi !== cur_hi || s_if.lo !== cur_lo) hold_bad++;
      end
      if (n == 1 && fast_mul) begin
        chk({tag, "_fdone"}, f_if.done, 1'b1);
        chk({tag, "_fbusy"}, f_if.busy, 1'b0);
        chk({tag, "_fhi"}, f_if.hi, eh);
        chk({tag, "_flo"}, f_if.lo, el);
      end
      if (glitch != 0 && n == glitch) begin
        s_if.start = 1'b1; s_if.op = 3'd2; s_if.Rdata1 = 32'd100; s_if.Rdata2 = 32'd7;
      end
      if (glitch != 0 && n == glitch + 1) s_if.start = 1'b0;
      if (n == W + 1) begin
        chk({tag, "_done"}, s_if.done, 1'b1);
        chk({tag, "_busy_end"}, s_if.busy, 1'b0);
        chk({tag, "_hi"}, s_if.hi, eh);
        chk({tag, "_lo"}, s_if.lo, el);
        chk({tag, "_dz"}, s_if.div_zero, ed);
        if (!fast_mul) begin
          chk({tag, "_fdone"}, f_if.done, 1'b1);
          chk({tag, "_fhi"}, f_if.hi, eh);
          chk({tag, "_flo"}, f_if.lo, el);
          chk({tag, "_fdz"}, f_if.div_zero, ed);
        end
      end
    end
    chk({tag, "_busy_cycles"}, busy_n, W);
    chk({tag, "_hold"}, hold_bad, 0);
    @(posedge CLK); #1;
    chk({tag, "_done_off"}, s_if.done, 1'b0);
    chk({tag, "_dz_off"}, s_if.div_zero, 1'b0);
    cur_hi = eh; cur_lo = el;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    logic [2:0] rop;
    drive(1'b0, 3'd7, '0, '0);
    #2 RST = 1'b0;
    #2;
    chk("rst_busy", s_if.busy, 1'b0);
    chk("rst_done", s_if.done, 1'b0);
    chk("rst_hi", s_if.hi, '0);
    chk("rst_lo", s_if.lo, '0);
    chk("rst_dz", s_if.div_zero, 1'b0);
    chk("rst_fhi", f_if.hi, '0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST = 1'b1;

    run_op(3'd0, 32'hFFFF_FFFF, 32'h2, 0, "mult_m1x2");
    run_op(3'd1, 32'hFFFF_FFFF, 32'h2, 0, "multu_m1x2");
    run_op(3'd2, 32'hFFFF_FFF9, 32'h2, 0, "div_m7_2");
    run_op(3'd3, 32'd7, 32'd2, 0, "divu_7_2");
    run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 0, "div_7_m2");
    run_op(3'd2, 32'd5, 32'd0, 0, "div_by_zero");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run_op(3'd1, 32'hDEAD_BEEF, 32'h1234_5677, 5, "multu_ignore_start");
    run_op(3'd4, 32'h1234_5678, 32'h0, 0, "mthi");
    run_op(3'd5, 32'hCAFE_F00D, 32'h0, 0, "mtlo");
    run_op(3'd6, 32'h1111_1111, 32'h2, 0, "noop6");

    // Abort a divide mid-flight with an asynchronous reset.
    @(negedge CLK); drive(1'b1, 3'd2, 32'd1000, 32'd3);
    @(posedge CLK); #1;
    @(negedge CLK); drive(1'b0, 3'd7, '0, '0);
    repeat (10) @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("abort_busy", s_if.busy, 1'b0);
    chk("abort_done", s_if.done, 1'b0);
    chk("abort_hi", s_if.hi, '0);
    chk("abort_lo", s_if.lo, '0);
    chk("abort_dz", s_if.div_zero, 1'b0);
    chk("abort_flo", f_if.lo, '0);
    cur_hi = '0; cur_lo = '0;
    @(negedge CLK); @(negedge CLK) RST = 1'b1;
    run_op(3'd1, 32'd3, 32'd4, 0, "multu_3x4");

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      run_op(rop, pick(), pick(), 0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multiply/divide unit with architectural HI/LO registers, sitting beside the EX-stage ALU. It executes MULT, MULTU, DIV and DIVU over multiple cycles, holds results in HI/LO, and exposes a busy/done handshake so the pipeline can stall dependent MFHI/MFLO reads. It also supports direct MTHI/MTLO writes. It is parametrised in datapath width and has an optional single-cycle multiply mode.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; must be ≥ 4.
- FAST_MUL, 0, selects the multiply mode. 1 = single-cycle multiply using `*`. 0 = iterative shift-add multiply. Divide is always iterative.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset; asynchronous, active-low. Clears all state immediately.
- start  in  1  request valid; sampled on a rising edge.
- op  in  3  operation select:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110 and 111 are no-ops.
- Rdata1  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO source.
- Rdata2  in  WIDTH  rt operand: multiplier or divisor.
- busy  out  1  a mul/div operation is in flight.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- div_zero  out  1  high together with done when the divisor was 0; otherwise 0.

## Operation
- States: IDLE, RUN, FIX.
- Reset value of every output is 0 (busy, done, hi, lo, div_zero). State goes to IDLE and the iteration counter to 0.
- Accepting a request (IDLE and start=1):
  - Mul/div op: latch operands. For signed ops, latch the absolute values and the result sign bits. Go to RUN with counter=0. MULT/MULTU with FAST_MUL=1 goes straight to FIX with the full 2·WIDTH product precomputed.
  - MTHI/MTLO: write Rdata1 to hi/lo at that edge. State stays IDLE; busy and done stay 0.
  - No-op codes: nothing happens.
- RUN:
  - One iteration per edge.
  - Multiply: shift-add on a 2·WIDTH accumulator.
  - Divide: restoring divide, one quotient bit per edge, MSB first.
  - After WIDTH iterations, go to FIX.
- FIX:
  - Apply sign correction: product negated if the operand signs differ; quotient negated if the signs differ; remainder takes the dividend's sign.
  - Write hi/lo, pulse done, return to IDLE.
- Result placement:
  - Multiply: hi = product[2·WIDTH-1:WIDTH], lo = product[WIDTH-1:0]. MULT is signed, MULTU unsigned.
  - Divide: lo = quotient, hi = remainder. Signed quotient truncates toward zero.
- Divide by zero: lo = all ones, hi = the Rdata1 value latched at start, div_zero=1 with done. Latency is the normal divide latency.
- Signed overflow (most-negative value / -1): lo = most-negative value, hi = 0, no flag.
- start while busy=1: ignored, including MTHI/MTLO. Operands are not re-latched.
- hi/lo keep their old values until the FIX edge, so MFHI/MFLO must stall on busy.
- RST low mid-operation: the operation is aborted and all outputs clear asynchronously. Nothing is written to hi/lo afterwards.

## Timing
- Start is sampled at edge 0; "cycle n" means the cycle after edge n.
- Iterative operation (divide always; multiply when FAST_MUL=0):
  - busy=1 in cycles 0..WIDTH.
  - Iterations occur on edges 1..WIDTH.
  - FIX occurs at edge WIDTH+1.
  - done=1, busy=0 and hi/lo updated in cycle WIDTH+1.
  - A new start is accepted at edge WIDTH+1, so back-to-back throughput is one operation per WIDTH+1 cycles.
- FAST_MUL=1 multiply: busy=1 in cycle 0, done=1 and hi/lo valid in cycle 1.
- MTHI/MTLO: hi/lo hold the new value in cycle 0.
- done lasts exactly one cycle. div_zero goes high and low together with done.

## Test plan
1. WIDTH=32, FAST_MUL=0, MULT with Rdata1=0xFFFFFFFF and Rdata2=0x00000002:
   - Required: busy high in cycles 0..32; done in cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFFE.
   - Repeat with MULTU: hi=0x00000001, lo=0xFFFFFFFE.
2. Divides:
   - DIV -7 (0xFFFFFFF9) / 2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
   - DIVU 7 / 2: lo=3, hi=1.
   - DIV 7 / -2: lo=0xFFFFFFFD, hi=1.
   - All three: done in cycle 33.
3. DIV 5 / 0: done in cycle 33 with div_zero=1, hi=5, lo=0xFFFFFFFF. div_zero=0 in cycle 34.
4. DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, div_zero=0.
5. Handshake:
   - Start MULTU, then pulse start with DIV in cycle 5: ignored, and the MULTU result is unchanged.
   - MTHI 0x12345678 issued while idle: hi=0x12345678 in the next cycle; busy and done stay 0.
6. Reset and fast mode:
   - Drive RST low in cycle 10 of a DIV: all outputs 0 immediately.
   - After release, MULTU 3×4 gives hi=0, lo=12 in cycle 33.
   - With FAST_MUL=1, MULTU 3×4 gives done and lo=12 in cycle 1.
